// File: rtl/count_pkg.sv
// Shared definitions for the push-button pulse generator and its downstream counter bench.
// State encoding is fixed so other benches can decode the exported state.
package count_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_HOLD_CYCLES     = 16;
   localparam int DEF_REPEAT_CYCLES   = 8;
   localparam int DEF_CNT_W           = 8;

endpackage : count_pkg

// File: rtl/count_pulse_gen_sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter.
// dout_level only follows the synchronized input after it has differed for DEBOUNCE_CYCLES cycles.
module sync_debounce
   import count_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout_level
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_debounce
      $error("sync_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

   // Any sample that agrees with the current level restarts the count.
   always_comb begin
      level_d   = level_q;
      deb_cnt_d = '0;
      if (s2_q != level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            level_d = s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         level_q   <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         s1_q      <= din;
         s2_q      <= s1_q;
         level_q   <= level_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   assign dout_level = level_q;

endmodule : sync_debounce

// File: rtl/count_pulse_gen.sv
// Push-button to count_up pulse generator with hold-to-auto-repeat.
// One pulse on a debounced press, one after HOLD_CYCLES, then one every REPEAT_CYCLES while held.
module count_pulse_gen
   import count_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       enable,
   output logic       count_up,
   output logic       btn_level,
   output logic       repeat_active,
   output logic [1:0] state_dbg
);

   if (HOLD_CYCLES < 2 || HOLD_CYCLES > (2**CNT_W) - 1) begin : g_bad_hold
      $error("count_pulse_gen: HOLD_CYCLES out of range for CNT_W");
   end
   if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > (2**CNT_W) - 1) begin : g_bad_repeat
      $error("count_pulse_gen: REPEAT_CYCLES out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic             btn_level_d_q;
   logic             count_up_q, count_up_d;
   logic             repeat_active_q, repeat_active_d;
   logic             rise;

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_sync_debounce (
      .clock      (clock),
      .reset      (reset),
      .din        (btn_raw),
      .dout_level (btn_level)
   );

   assign rise = btn_level & ~btn_level_d_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // Disable wins over everything; a release wins over a coincident timer expiry.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      if (!enable) begin
         state_d = IDLE;
         tmr_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               tmr_d = '0;
               if (rise) state_d = PRESSED;
            end
            PRESSED: begin
               if (!btn_level) begin
                  state_d = IDLE;
                  tmr_d   = '0;
               end else if (tmr_q == HOLD_LAST) begin
                  state_d = REPEAT;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (!btn_level) begin
                  state_d = IDLE;
                  tmr_d   = '0;
               end else if (tmr_q == REPEAT_LAST) begin
                  tmr_d = '0;
               end else begin
                  tmr_d = tmr_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               tmr_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      count_up_d      = 1'b0;
      repeat_active_d = (state_q == REPEAT);
      if (enable) begin
         case (state_q)
            IDLE:    count_up_d = rise;
            PRESSED: count_up_d = btn_level && (tmr_q == HOLD_LAST);
            REPEAT:  count_up_d = btn_level && (tmr_q == REPEAT_LAST);
            default: count_up_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_level_d_q   <= 1'b0;
         count_up_q      <= 1'b0;
         repeat_active_q <= 1'b0;
      end else begin
         btn_level_d_q   <= btn_level;
         count_up_q      <= count_up_d;
         repeat_active_q <= repeat_active_d;
      end
   end

   assign count_up      = count_up_q;
   assign repeat_active = repeat_active_q;
   assign state_dbg     = state_q;

endmodule : count_pulse_gen

// File: tb/tb_count_pulse_gen.sv
// Directed and randomized bench for count_pulse_gen against a press/hold timing model.
module tb_count_pulse_gen;
   import count_pkg::*;

   localparam int D = DEF_DEBOUNCE_CYCLES;
   localparam int H = DEF_HOLD_CYCLES;
   localparam int R = DEF_REPEAT_CYCLES;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       btn_raw = 1'b0;
   logic       enable = 1'b0;
   logic       count_up, btn_level, repeat_active;
   logic [1:0] state_dbg;

   always #5 clock = ~clock;

   count_pulse_gen dut (
      .clock         (clock),
      .reset         (reset),
      .btn_raw       (btn_raw),
      .enable        (enable),
      .count_up      (count_up),
      .btn_level     (btn_level),
      .repeat_active (repeat_active),
      .state_dbg     (state_dbg)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model: raw-sample history, debounced level with run length, and the current hold session.
   bit         m_r1, m_r2, m_lvl, m_lvl_d, m_sess, m_pulse, m_rep;
   int         m_run, m_start;
   logic [1:0] m_state;

   int   pulse_log[$];
   int   lvl_rise_log[$];
   logic prev_lvl_obs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_r1 = 0; m_r2 = 0; m_lvl = 0; m_lvl_d = 0;
      m_sess = 0; m_pulse = 0; m_rep = 0;
      m_run = 0; m_start = 0;
      m_state = IDLE;
      prev_lvl_obs = 1'b0;
   endtask

   task automatic model_edge(input bit raw, input bit en);
      bit lvl_prev, rise;
      int age;
      lvl_prev = m_lvl;
      rise     = m_lvl & ~m_lvl_d;
      m_rep    = m_sess && (cyc - m_start >= H);
      cyc++;
      if (m_r2 != m_lvl) begin
         m_run++;
         if (m_run == D) begin
            m_lvl = m_r2;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      m_lvl_d = lvl_prev;
      m_pulse = 0;
      if (!en) begin
         m_sess = 0;
      end else if (m_sess) begin
         if (!lvl_prev) begin
            m_sess = 0;
         end else begin
            age = cyc - m_start;
            if (age == H || (age > H && (age - H) % R == 0)) m_pulse = 1;
         end
      end else if (rise) begin
         m_sess  = 1;
         m_start = cyc;
         m_pulse = 1;
      end
      m_state = !m_sess ? IDLE : ((cyc - m_start >= H) ? REPEAT : PRESSED);
      m_r2 = m_r1;
      m_r1 = raw;
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset) model_edge(btn_raw, enable);
      #1;
      check("count_up", count_up, m_pulse);
      check("btn_level", btn_level, m_lvl);
      check("repeat_active", repeat_active, m_rep);
      check("state", state_dbg, m_state);
      if (count_up === 1'b1) pulse_log.push_back(cyc);
      if (btn_level === 1'b1 && prev_lvl_obs !== 1'b1) lvl_rise_log.push_back(cyc);
      prev_lvl_obs = btn_level;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count_up"}, count_up, 0);
      check({tag, "_btn_level"}, btn_level, 0);
      check({tag, "_repeat_active"}, repeat_active, 0);
      check({tag, "_state"}, state_dbg, IDLE);
   endtask

   int k;
   int offs[7];

   initial begin
      model_reset();
      offs = '{0, H, H + R, H + 2*R, H + 3*R, H + 4*R, H + 5*R};

      // Asynchronous reset before any clock edge
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_async");
      steps(2);
      @(negedge clock) reset = 1'b0;
      enable = 1'b1;
      steps(20);
      check("idle_no_pulse", pulse_log.size(), 0);

      // Clean press
      pulse_log.delete(); lvl_rise_log.delete();
      btn_raw = 1'b1;
      k = cyc + 1;
      steps(10);
      btn_raw = 1'b0;
      steps(D + 6);
      check("press_lvl_count", lvl_rise_log.size(), 1);
      if (lvl_rise_log.size() == 1) check("press_lvl_latency", lvl_rise_log[0] - k, D + 1);
      check("press_pulse_count", pulse_log.size(), 1);
      if (pulse_log.size() == 1) check("press_pulse_latency", pulse_log[0] - k, D + 2);

      // Bounce shorter than the debounce window
      pulse_log.delete(); lvl_rise_log.delete();
      btn_raw = 1'b1; step();
      btn_raw = 1'b0; step();
      btn_raw = 1'b1; step();
      btn_raw = 1'b0; steps(15);
      check("bounce_lvl", lvl_rise_log.size(), 0);
      check("bounce_pulse", pulse_log.size(), 0);

      // Auto-repeat over a 60-cycle hold
      pulse_log.delete();
      btn_raw = 1'b1;
      steps(60);
      btn_raw = 1'b0;
      steps(D + 6);
      check("repeat_pulse_count", pulse_log.size(), 7);
      if (pulse_log.size() == 7)
         for (int i = 0; i < 7; i++) check("repeat_offset", pulse_log[i] - pulse_log[0], offs[i]);

      // Enable dropped mid-hold, raised again while still held
      pulse_log.delete();
      btn_raw = 1'b1;
      steps(D + 2 + 5 + 1);
      enable = 1'b0;
      steps(20);
      check("gate_state_idle", state_dbg, IDLE);
      enable = 1'b1;
      steps(10);
      check("gate_no_extra", pulse_log.size(), 1);
      check("gate_state_still_idle", state_dbg, IDLE);
      btn_raw = 1'b0;
      steps(D + 6);
      pulse_log.delete();
      btn_raw = 1'b1;
      steps(D + 6);
      btn_raw = 1'b0;
      steps(D + 6);
      check("gate_repress", pulse_log.size(), 1);

      // Randomized press/release/enable traffic
      for (int i = 0; i < 40; i++) begin
         btn_raw = 1'($urandom_range(0, 1));
         enable  = ($urandom_range(0, 9) != 0);
         steps($urandom_range(1, 30));
      end
      btn_raw = 1'b0;
      enable  = 1'b1;
      steps(D + 6);

      // Reset while auto-repeating
      btn_raw = 1'b1;
      steps(D + 2 + H + 4);
      check("pre_reset_repeat", repeat_active, 1);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_mid_repeat");
      model_reset();
      steps(2);
      @(negedge clock) reset = 1'b0;
      pulse_log.delete();
      k = cyc + 1;
      steps(D + 6);
      check("post_reset_pulse_count", pulse_log.size(), 1);
      if (pulse_log.size() == 1) check("post_reset_latency", pulse_log[0] - k, D + 2);
      btn_raw = 1'b0;
      steps(D + 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_count_pulse_gen
